cardinal_dmem_arbiter: RTL and testbench
========================================

# cardinal_dmem_arbiter

Round-robin arbiter that shares one 256 x 64-bit synchronous data memory (a `dmem` instance) between four Cardinal CMP requesters, such as the four node processors or a processor/NIC mix. It sits between the requesters' memory ports and the single memory port. Each cycle it grants at most one access, routes that requester's address, write data and enables to the memory, and steers the read data back to the requester with a matching valid pulse. It turns a four-way memory into a contended shared bank without changing the `dmem` model.

## Interface
Parameters:
- N_REQ, 4, number of requesters (fixed at 4 in this revision; the pointer is 2 bits)
- AW, 8, memory address width
- DW, 64, data width
- RD_LAT, 1, memory read latency in cycles from the grant edge to valid `mem_dout`

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high
- req_en  in  N_REQ  per-requester access request; held until acknowledged
- req_wr_en  in  N_REQ  1 = write, 0 = read; valid while req_en is high
- req_addr  in  N_REQ*AW  packed addresses; requester i uses slice [i*AW +: AW]
- req_wdata  in  N_REQ*DW  packed write data; requester i uses slice [i*DW +: DW]
- req_ack  out  N_REQ  one-hot; combinational; high in the cycle requester i's access is issued
- rd_valid  out  N_REQ  one-hot; registered; read data for requester i is on rd_data
- rd_data  out  DW  read data, valid when any rd_valid bit is high
- mem_en  out  1  to dmem memEn
- mem_wr_en  out  1  to dmem memWrEn
- mem_addr  out  AW  to dmem memAddr
- mem_din  out  DW  to dmem dataIn
- mem_dout  in  DW  from dmem dataOut

## Operation
- Arbitration:
  - Registered 2-bit priority pointer `ptr`; reset value 0.
  - Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
  - The first requester with req_en high wins.
- Issue:
  - The winner's req_ack bit is set.
  - mem_en = 1; mem_wr_en, mem_addr and mem_din are muxed from the winner.
  - With no request: mem_en = 0, mem_wr_en = 0, mem_addr = 0, mem_din = 0.
- Pointer update:
  - On a grant to i: ptr <= (i+1) mod 4.
  - With no grant: ptr holds.
- Read return:
  - A shift register RD_LAT deep carries {valid, one-hot id}.
  - rd_valid is that register's output; rd_data = mem_dout, passed through combinationally.
  - Writes produce no rd_valid.
- Requester protocol:
  - Keep req_en and its fields stable until req_ack is seen.
  - After req_ack, a new request may be presented in the next cycle.
  - A requester may have several reads in flight. Responses return in issue order.
- Fairness: any continuously requesting port is granted within 4 cycles.
- Reset:
  - While RESET is high, all outputs are forced to 0 (req_ack, mem_en and the rest).
  - ptr <= 0 and the response pipe is cleared.
  - Reads in flight when RESET is asserted are dropped: no rd_valid after reset.

## Timing
- Grant latency: 0 cycles. req_ack is asserted in the same cycle as req_en when the requester wins.
- Memory write takes effect at the rising edge that ends the ack cycle.
- Read data returns RD_LAT cycles after the ack cycle (1 cycle by default), and rd_valid is asserted in that same cycle.
- Throughput: one access per cycle, with no bubbles between different requesters.
- Simultaneous read of address A by requester i and write of A by requester j: they are serialized by grant order. A read granted before the write sees the old value; a read granted after sees the new value.
- Pointer wrap: after a grant to requester 3, ptr = 0.
- The first cycle after RESET deasserts is a normal arbitration cycle with ptr = 0.

## Structure
- Shared package `cardinal_cmp_pkg`: N_REQ, AW and DW constants, plus a function that converts a one-hot requester id to its index.
- One natural sub-module, `cardinal_rr_pick4`: a purely combinational rotate-priority encoder.
  - Inputs: req[4], ptr[2].
  - Outputs: gnt one-hot, gnt_idx[2], any.
- Top level holds the pointer register, the issue mux and the response pipe.

## Test plan
- Single reader: requester 2 reads address 0x10, which holds 0x1122334455667788.
  - req_ack = 0100 in the same cycle; mem_addr = 0x10.
  - Next cycle: rd_valid = 0100 and rd_data = 0x1122334455667788.
- All four request continuously from reset: acks rotate 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no idle cycle.
- ptr = 2 with requesters 0 and 3 both requesting:
  - Requester 3 is acked first and ptr becomes 0.
  - Requester 0 is acked next cycle.
- Requester 1 writes 0xDEADBEEF00000000 to 0x05 while requester 2 reads 0x05, with ptr = 1:
  - The write is acked first and the read second.
  - The read returns 0xDEADBEEF00000000.
- RESET is asserted in the cycle after a read ack to requester 0:
  - No rd_valid is seen.
  - All outputs read 0 during reset.
  - After release, a requester 3 request is acked only when no lower index competes, because ptr = 0.
- Idle bus: no requests for 10 cycles.
  - mem_en stays 0 and rd_valid stays 0.
  - ptr is unchanged, checked by the next grant order.

Source files
------------

// File: rtl/cardinal_cmp_pkg.sv
// Shared definitions for the Cardinal CMP memory-side blocks.
//   CMP_N_REQ : number of requesters sharing one data memory
//   CMP_AW    : data memory address width
//   CMP_DW    : data memory word width
//   PTR_W     : width of a requester index / round-robin pointer
//   onehot_to_idx : converts a one-hot requester id to its index
package cardinal_cmp_pkg;

    localparam int CMP_N_REQ = 4;
    localparam int CMP_AW    = 8;
    localparam int CMP_DW    = 64;
    localparam int PTR_W     = 2;

    // OR-reduction of the set bit positions; exact for one-hot input,
    // and yields 0 for an all-zero vector.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [CMP_N_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < CMP_N_REQ; i++) begin
            if (oh[i]) idx = idx | PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cardinal_rr_pick4.sv
// Combinational rotate-priority encoder for four requesters.
//   req     : request vector
//   ptr     : highest-priority requester index this cycle
//   gnt     : one-hot grant (first requester at or after ptr, wrapping)
//   gnt_idx : index of the granted requester (0 when none)
//   any     : at least one request present
module cardinal_rr_pick4
    import cardinal_cmp_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        // Walk ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps mod 4.
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
            end
        end
        gnt_idx = onehot_to_idx(gnt);
    end

endmodule

// File: rtl/cardinal_dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory among four requesters.
//   CLK, RESET            : clock, synchronous active-high reset
//   req_en/req_wr_en      : per-requester request and write flag
//   req_addr/req_wdata    : packed per-requester address and write data
//   req_ack               : one-hot, combinational grant of this cycle
//   rd_valid/rd_data      : one-hot read-return strobe and returned data
//   mem_en..mem_din       : single memory port driven by the winner
//   mem_dout              : memory read data
module cardinal_dmem_arbiter
    import cardinal_cmp_pkg::*;
#(
    parameter int N_REQ  = CMP_N_REQ,
    parameter int AW     = CMP_AW,
    parameter int DW     = CMP_DW,
    parameter int RD_LAT = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [N_REQ-1:0]    req_en,
    input  logic [N_REQ-1:0]    req_wr_en,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    req_ack,
    output logic [N_REQ-1:0]    rd_valid,
    output logic [DW-1:0]       rd_data,
    output logic                mem_en,
    output logic                mem_wr_en,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_din,
    input  logic [DW-1:0]       mem_dout
);

    logic [1:0]       ptr;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       gnt_idx;
    logic             any;

    logic             vld_p [RD_LAT];
    logic [N_REQ-1:0] id_p  [RD_LAT];

    cardinal_rr_pick4 u_pick (
        .req     (req_en),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Issue stage: winner drives the memory port; all zero when idle or in reset.
    always_comb begin
        req_ack   = '0;
        mem_en    = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if (!RESET && any) begin
            req_ack   = gnt;
            mem_en    = 1'b1;
            mem_wr_en = req_wr_en[gnt_idx];
            mem_addr  = req_addr[int'(gnt_idx)*AW +: AW];
            mem_din   = req_wdata[int'(gnt_idx)*DW +: DW];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)    ptr <= '0;
        else if (any) ptr <= gnt_idx + 2'd1;
    end

    // Response pipe: stage 0 captured at the grant edge, output after RD_LAT edges.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < RD_LAT; k++) vld_p[k] <= 1'b0;
        end else begin
            vld_p[0] <= mem_en && !mem_wr_en;
            for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        id_p[0] <= gnt;
        for (int k = 1; k < RD_LAT; k++) id_p[k] <= id_p[k-1];
    end

    // Return stage: strobe gated by the pipe valid; data straight from memory.
    assign rd_valid = (!RESET && vld_p[RD_LAT-1]) ? id_p[RD_LAT-1] : '0;
    assign rd_data  = RESET ? '0 : mem_dout;

endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
module tb_cardinal_dmem_arbiter;

    logic         CLK;
    logic         RESET;
    logic [3:0]   req_en;
    logic [3:0]   req_wr_en;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic [3:0]   req_ack;
    logic [3:0]   rd_valid;
    logic [63:0]  rd_data;
    logic         mem_en;
    logic         mem_wr_en;
    logic [7:0]   mem_addr;
    logic [63:0]  mem_din;
    logic [63:0]  mem_dout;

    int checks   = 0;
    int failures = 0;
    logic [3:0] ack_seen = '0;

    cardinal_dmem_arbiter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_en    (req_en),
        .req_wr_en (req_wr_en),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_en    (mem_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [63:0] init_val(input int a);
        if (a == 16) return 64'h1122334455667788;
        return 64'h0123456789ABCDEF ^ (64'(a) * 64'h9E3779B97F4A7C15);
    endfunction

    // Behavioural dmem: 256 x 64, one-cycle synchronous read.
    logic [63:0] dmem [256];
    initial begin
        for (int a = 0; a < 256; a++) dmem[a] = init_val(a);
        mem_dout = '0;
        forever begin
            @(posedge CLK);
            if (mem_en) begin
                if (mem_wr_en) dmem[mem_addr] <= mem_din;
                else           mem_dout       <= dmem[mem_addr];
            end
        end
    end

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        chk64(name, {60'b0, act}, {60'b0, exp});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: memory image, priority pointer, queue of pending reads.
    typedef struct {
        int          due;
        int          id;
        logic [63:0] data;
    } rsp_t;

    initial begin
        logic [63:0] ref_mem [256];
        rsp_t        pend [$];
        rsp_t        e;
        int          mptr;
        int          cyc;
        int          w;
        int          a;
        logic [3:0]  x_ack, x_rv;
        logic        x_en, x_wr;
        logic [7:0]  x_addr;
        logic [63:0] x_din, x_rd;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        mptr = 0;
        cyc  = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            x_ack = '0; x_rv = '0; x_en = 1'b0; x_wr = 1'b0;
            x_addr = '0; x_din = '0; x_rd = '0;
            if (RESET) begin
                mptr = 0;
                pend.delete();
                chk64("m_rst_rd_data", rd_data, 64'h0);
            end else begin
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    e    = pend.pop_front();
                    x_rv = 4'(1 << e.id);
                    x_rd = e.data;
                end
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    if (w < 0 && req_en[(mptr + k) % 4]) w = (mptr + k) % 4;
                end
                if (w >= 0) begin
                    x_ack  = 4'(1 << w);
                    x_en   = 1'b1;
                    x_wr   = req_wr_en[w];
                    x_addr = req_addr[w*8 +: 8];
                    x_din  = req_wdata[w*64 +: 64];
                end
                if (x_rv != 0) chk64("m_rd_data", rd_data, x_rd);
                if (w >= 0) begin
                    a = int'(x_addr);
                    if (x_wr) ref_mem[a] = x_din;
                    else      pend.push_back('{cyc + 1, w, ref_mem[a]});
                    mptr = (w + 1) % 4;
                end
            end
            chk4 ("m_req_ack",  req_ack,  x_ack);
            chk4 ("m_rd_valid", rd_valid, x_rv);
            chk4 ("m_mem_en",   {3'b0, mem_en},    {3'b0, x_en});
            chk4 ("m_mem_wr",   {3'b0, mem_wr_en}, {3'b0, x_wr});
            chk64("m_mem_addr", {56'b0, mem_addr}, {56'b0, x_addr});
            chk64("m_mem_din",  mem_din, x_din);
            ack_seen = req_ack;
        end
    end

    initial begin
        logic [3:0] rot [5];
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        RESET = 1'b1;
        req_en = 4'hF; req_wr_en = '0; req_addr = '0; req_wdata = '0;

        // Reset holds every output low even with all requesters asking.
        tick(); tick(); tick();
        @(negedge CLK);
        chk4 ("rst_ack",    req_ack,  4'b0);
        chk4 ("rst_mem_en", {3'b0, mem_en}, 4'b0);
        chk4 ("rst_rv",     rd_valid, 4'b0);
        chk64("rst_addr",   {56'b0, mem_addr}, 64'h0);

        // Single reader: requester 2 reads 0x10.
        tick();
        RESET = 1'b0;
        req_en = 4'b0100; req_addr[16 +: 8] = 8'h10;
        @(negedge CLK);
        chk4 ("rd1_ack",  req_ack, 4'b0100);
        chk64("rd1_addr", {56'b0, mem_addr}, 64'h10);
        tick();
        req_en = '0;
        @(negedge CLK);
        chk4 ("rd1_rv",   rd_valid, 4'b0100);
        chk64("rd1_data", rd_data, 64'h1122334455667788);

        // Rotation of all four from a fresh reset.
        tick(); RESET = 1'b1;
        tick(); RESET = 1'b0;
        req_en = 4'hF;
        for (int i = 0; i < 4; i++) req_addr[i*8 +: 8] = 8'(i);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk4("rot_ack", req_ack, rot[k]);
            tick();
        end

        // ptr=1: grant 1 so ptr=2, then 0 and 3 compete.
        req_en = 4'b0010;
        @(negedge CLK); chk4("p2_setup", req_ack, 4'b0010);
        tick(); req_en = 4'b1001;
        @(negedge CLK); chk4("p2_first", req_ack, 4'b1000);
        tick(); req_en = 4'b0001;
        @(negedge CLK); chk4("p2_second", req_ack, 4'b0001);

        // ptr=1: write by 1 and read by 2 of the same address.
        tick();
        req_en = 4'b0110;
        req_wr_en = 4'b0010;
        req_addr[8 +: 8] = 8'h05; req_addr[16 +: 8] = 8'h05;
        req_wdata[64 +: 64] = 64'hDEADBEEF00000000;
        @(negedge CLK);
        chk4("wr_ack",  req_ack, 4'b0010);
        chk4("wr_flag", {3'b0, mem_wr_en}, 4'b0001);
        tick(); req_en = 4'b0100; req_wr_en = '0;
        @(negedge CLK); chk4("rw_ack", req_ack, 4'b0100);

        // Read return from requester 2 while requester 0 issues a read.
        tick(); req_en = 4'b0001; req_addr[7:0] = 8'h10;
        @(negedge CLK);
        chk4 ("rw_rv",   rd_valid, 4'b0100);
        chk64("rw_data", rd_data, 64'hDEADBEEF00000000);
        chk4 ("r0_ack",  req_ack, 4'b0001);

        // Reset right after the read ack drops the return.
        tick(); RESET = 1'b1; req_en = '0;
        @(negedge CLK);
        chk4 ("drop_rv",  rd_valid, 4'b0);
        chk64("drop_rd",  rd_data, 64'h0);
        chk4 ("drop_en",  {3'b0, mem_en}, 4'b0);
        tick(); req_en = 4'b1010;
        @(negedge CLK); chk4("drop_ack", req_ack, 4'b0);
        tick(); RESET = 1'b0;
        @(negedge CLK);
        chk4("post_ack", req_ack, 4'b0010);
        chk4("post_rv",  rd_valid, 4'b0);
        tick(); req_en = 4'b1000;
        @(negedge CLK); chk4("post_ack3", req_ack, 4'b1000);
        tick(); req_en = 4'b0001; req_wr_en = 4'b0001; req_addr[7:0] = 8'h20;
        @(negedge CLK); chk4("post_ack0", req_ack, 4'b0001);

        // Idle bus, ptr left at 1.
        tick(); req_en = '0; req_wr_en = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk4("idle_en", {3'b0, mem_en}, 4'b0);
            chk4("idle_rv", rd_valid, 4'b0);
            tick();
        end
        req_en = 4'hF;
        @(negedge CLK); chk4("idle_ptr", req_ack, 4'b0010);
        tick(); req_en = '0;

        // Randomized traffic; requesters hold until acked.
        for (int c = 0; c < 1500; c++) begin
            tick();
            RESET = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                if (req_en[i] && ack_seen[i]) req_en[i] = 1'b0;
                if (!req_en[i] && $urandom_range(0, 99) < 60) begin
                    req_en[i]            = 1'b1;
                    req_wr_en[i]         = ($urandom_range(0, 99) < 30);
                    req_addr[i*8 +: 8]   = 8'($urandom_range(0, 15));
                    req_wdata[i*64 +: 64] = {$urandom, $urandom};
                end
            end
        end
        tick(); RESET = 1'b0; req_en = '0;
        tick(); tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
